// File: rtl/cla_pipe_addsub.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready.
// Optional signed saturation compiled in with CLA_SAT_EN.
module cla_pipe_addsub #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NG = WIDTH / 4;

  logic             r_v1;
  logic             r_v2;
  logic [WIDTH-1:0] r_p;
  logic [WIDTH-1:0] r_g;
  logic [NG-1:0]    r_gp;
  logic [NG-1:0]    r_gg;
  logic             r_c0;

  logic             w_s1_load;
  logic             w_s2_load;
  logic [WIDTH-1:0] w_beff;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH-1:0] w_g;
  logic [NG-1:0]    w_gp;
  logic [NG-1:0]    w_gg;
  logic [NG:0]      w_gc;
  logic [WIDTH-1:0] w_c;
  logic [WIDTH-1:0] w_raw;
  logic [WIDTH-1:0] w_res;
  logic             w_cout;
  logic             w_ovf;

  assign in_ready  = !r_v1 || !r_v2 || out_ready;
  assign w_s1_load = in_valid && in_ready;
  assign w_s2_load = r_v1 && (!r_v2 || out_ready);
  assign out_valid = r_v2;

  assign w_beff = b ^ {WIDTH{sub}};
  assign w_p    = a ^ w_beff;
  assign w_g    = a & w_beff;

  always_comb begin
    w_gp = '0;
    w_gg = '0;
    for (int k = 0; k < NG; k++) begin
      w_gp[k] = &w_p[4*k +: 4];
      w_gg[k] = w_g[4*k+3]
              | (w_p[4*k+3] & w_g[4*k+2])
              | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
              | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1]
                 & w_g[4*k]);
    end
  end

`ifdef CLA_SAT_EN
  logic r_sat;
  logic r_amsb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sat  <= 1'b0;
      r_amsb <= 1'b0;
    end else if (w_s1_load) begin
      r_sat  <= sat;
      r_amsb <= a[WIDTH-1];
    end
  end
`else
  logic w_unused_sat;
  assign w_unused_sat = sat;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1 <= 1'b0;
      r_p  <= '0;
      r_g  <= '0;
      r_gp <= '0;
      r_gg <= '0;
      r_c0 <= 1'b0;
    end else begin
      if (w_s1_load) begin
        r_v1 <= 1'b1;
        r_p  <= w_p;
        r_g  <= w_g;
        r_gp <= w_gp;
        r_gg <= w_gg;
        r_c0 <= cin ^ sub;
      end else if (w_s2_load) begin
        r_v1 <= 1'b0;
      end
    end
  end

  // Each group carry is a flat sum of products over all lower groups.
  always_comb begin : s2_gc
    logic t;
    t    = 1'b0;
    w_gc = '0;
    w_gc[0] = r_c0;
    for (int k = 1; k <= NG; k++) begin
      t = r_c0;
      for (int m = 0; m < k; m++)
        t = t & r_gp[m];
      w_gc[k] = t;
      for (int j = 0; j < k; j++) begin
        t = r_gg[j];
        for (int m = j + 1; m < k; m++)
          t = t & r_gp[m];
        w_gc[k] = w_gc[k] | t;
      end
    end
  end

  always_comb begin
    w_c = '0;
    for (int k = 0; k < NG; k++) begin
      w_c[4*k] = w_gc[k];
      for (int i = 1; i < 4; i++)
        w_c[4*k+i] = r_g[4*k+i-1]
                   | (r_p[4*k+i-1] & w_c[4*k+i-1]);
    end
  end

  assign w_raw  = r_p ^ w_c;
  assign w_cout = w_gc[NG];
  assign w_ovf  = w_c[WIDTH-1] ^ w_gc[NG];

`ifdef CLA_SAT_EN
  always_comb begin
    w_res = w_raw;
    if (r_sat && w_ovf)
      w_res = r_amsb ? {1'b1, {(WIDTH-1){1'b0}}}
                     : {1'b0, {(WIDTH-1){1'b1}}};
  end
`else
  assign w_res = w_raw;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v2 <= 1'b0;
      sum  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
      zero <= 1'b0;
    end else begin
      if (w_s2_load) begin
        r_v2 <= 1'b1;
        sum  <= w_res;
        cout <= w_cout;
        ovf  <= w_ovf;
        zero <= ~|w_res;
      end else if (out_ready) begin
        r_v2 <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Directed and streaming checks for cla_pipe_addsub (WIDTH=16).
// Saturation vectors switch expectations when CLA_SAT_EN is defined.
module tb_cla_pipe_addsub;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        sat;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;
  logic        zero;

  int n_checks = 0;
  int n_errors = 0;

  cla_pipe_addsub #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .sat(sat),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: {sum, cout, ovf, zero}
  function automatic logic [18:0] model(
    input logic [15:0] ma, input logic [15:0] mb,
    input logic mcin, input logic msub, input logic msat);
    logic [15:0] be;
    logic [16:0] full;
    logic [15:0] s;
    logic        ov;
    be   = msub ? ~mb : mb;
    full = {1'b0, ma} + {1'b0, be} + {16'd0, mcin ^ msub};
    s    = full[15:0];
    ov   = (ma[15] == be[15]) && (s[15] != ma[15]);
`ifdef CLA_SAT_EN
    if (msat && ov) s = ma[15] ? 16'h8000 : 16'h7fff;
`else
    if (msat) s = full[15:0];
`endif
    return {s, full[16], ov, (s == 16'd0)};
  endfunction

  task automatic run_op(input string tag,
                        input logic [15:0] ta, input logic [15:0] tb,
                        input logic tcin, input logic tsub,
                        input logic tsat,
                        input logic [15:0] es, input logic ec,
                        input logic eo, input logic ez);
    @(negedge clk);
    a = ta; b = tb; cin = tcin; sub = tsub; sat = tsat;
    in_valid = 1'b1;
    #1 chk({tag, ".in_ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, ".lat1"}, out_valid, 0);
    @(negedge clk);
    chk({tag, ".valid"}, out_valid, 1);
    chk({tag, ".sum"}, sum, es);
    chk({tag, ".cout"}, cout, ec);
    chk({tag, ".ovf"}, ovf, eo);
    chk({tag, ".zero"}, zero, ez);
  endtask

  initial begin
    logic [18:0] q[$];
    logic [18:0] e;
    logic [18:0] held;
    logic        stall;
    int sent;
    int got;
    int cyc;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0; sat = 1'b0;
    #1;
    chk("rst.out_valid", out_valid, 0);
    chk("rst.sum", sum, 0);
    chk("rst.cout", cout, 0);
    chk("rst.ovf", ovf, 0);
    chk("rst.zero", zero, 0);
    chk("rst.in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op("add_00ff", 16'h00ff, 16'h0001, 0, 0, 0,
           16'h0100, 0, 0, 0);
    run_op("add_ffff", 16'hffff, 16'h0001, 0, 0, 0,
           16'h0000, 1, 0, 1);
    run_op("add_cin", 16'h1234, 16'h0000, 1, 0, 0,
           16'h1235, 0, 0, 0);
    run_op("add_ovf", 16'h7fff, 16'h0001, 0, 0, 0,
           16'h8000, 0, 1, 0);
`ifdef CLA_SAT_EN
    run_op("add_sat", 16'h7fff, 16'h0001, 0, 0, 1,
           16'h7fff, 0, 1, 0);
    run_op("sub_sat", 16'h8000, 16'h0001, 0, 1, 1,
           16'h8000, 1, 1, 0);
`else
    run_op("add_sat", 16'h7fff, 16'h0001, 0, 0, 1,
           16'h8000, 0, 1, 0);
    run_op("sub_sat", 16'h8000, 16'h0001, 0, 1, 1,
           16'h7fff, 1, 1, 0);
`endif
    run_op("sub_neg", 16'h0005, 16'h0007, 0, 1, 0,
           16'hfffe, 0, 0, 0);
    run_op("sub_bin", 16'h0007, 16'h0005, 1, 1, 0,
           16'h0001, 1, 0, 0);
    run_op("sub_eq", 16'h1234, 16'h1234, 0, 1, 0,
           16'h0000, 1, 0, 1);
    run_op("add_neg", 16'h8000, 16'h8000, 0, 0, 0,
           16'h0000, 1, 1, 1);
    run_op("add_carry", 16'h0fff, 16'hf001, 0, 0, 0,
           16'h0000, 1, 0, 1);

    sent = 0; got = 0; cyc = 0; stall = 1'b0; held = '0;
    while (got < 20 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      out_ready = 1'($urandom_range(0, 1));
      if (stall) begin
        chk("stall.valid", out_valid, 1);
        chk("stall.hold", {sum, cout, ovf, zero}, held);
      end
      if (sent < 20) begin
        in_valid = 1'b1;
        a = 16'($urandom);
        b = 16'($urandom);
        cin = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
        sat = 1'($urandom_range(0, 1));
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (!in_ready)
        chk("stream.in_ready_low", {out_valid, out_ready}, 2'b10);
      if (in_valid && in_ready) begin
        q.push_back(model(a, b, cin, sub, sat));
        sent++;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("stream.extra", 1, 0);
        end else begin
          e = q.pop_front();
          chk("stream.result", {sum, cout, ovf, zero}, e);
        end
        got++;
      end
      stall = out_valid && !out_ready;
      held  = {sum, cout, ovf, zero};
    end
    chk("stream.count", got, 20);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("stream.drained", out_valid, 0);

    out_ready = 1'b0;
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; cin = 0; sub = 0; sat = 0;
    in_valid = 1'b1;
    @(negedge clk);
    a = 16'h4444; b = 16'h1111;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("full.in_ready", in_ready, 0);
    chk("full.sum", sum, 16'h3333);
    rst = 1'b1;
    #1;
    chk("midrst.out_valid", out_valid, 0);
    chk("midrst.sum", sum, 0);
    chk("midrst.in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("postrst.idle1", out_valid, 0);
    @(negedge clk);
    chk("postrst.idle2", out_valid, 0);
    run_op("postrst", 16'h0101, 16'h0202, 0, 0, 0,
           16'h0303, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
